// File: rtl/command_decoder.sv
// Command decoder: validates a received {address, command} frame, queries the sensor bank
// with a timeout, and hands a two-byte {value, code} response to the UART transmitter.
module command_decoder #(
  parameter int NUM_SENSORS    = 32,
  parameter int TIMEOUT_CYCLES = 9600
) (
  input  logic        clk_9k6hz,
  input  logic        rst_n,
  input  logic [15:0] rx_data,
  input  logic        rx_concluded,
  output logic [7:0]  sensor_addr,
  output logic [1:0]  sensor_cmd,
  output logic        sensor_req,
  input  logic        sensor_done,
  input  logic        sensor_err,
  input  logic [7:0]  sensor_value,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [15:0] tx_data,
  output logic        overrun,
  output logic [2:0]  dbg_state_o
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    NUM_S9   = 9'(NUM_SENSORS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_REQ    = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t        state_q;
  logic          conc_q;
  logic [7:0]    cmd_q;
  logic [7:0]    addr_q;
  logic [7:0]    sensor_addr_q;
  logic [1:0]    sensor_cmd_q;
  logic          sensor_req_q;
  logic [7:0]    code_q;
  logic [7:0]    value_q;
  logic [CW-1:0] cnt_q;
  logic [15:0]   tx_data_q;
  logic          overrun_q;
  logic          new_frame_d;

  assign new_frame_d = rx_concluded && !conc_q;

  // Handshake: tx_start is a single-cycle strobe raised only in RESP while tx_busy is low;
  // tx_data carries the response during that strobe and holds it until the next one.
  assign tx_start = (state_q == S_RESP) && !tx_busy;
  assign tx_data  = tx_start ? {value_q, code_q} : tx_data_q;

  assign sensor_addr = sensor_addr_q;
  assign sensor_cmd  = sensor_cmd_q;
  assign sensor_req  = sensor_req_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk_9k6hz) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      conc_q        <= 1'b0;
      cmd_q         <= '0;
      addr_q        <= '0;
      sensor_addr_q <= '0;
      sensor_cmd_q  <= '0;
      sensor_req_q  <= 1'b0;
      code_q        <= '0;
      value_q       <= '0;
      cnt_q         <= '0;
      tx_data_q     <= '0;
      overrun_q     <= 1'b0;
    end else begin
      conc_q       <= rx_concluded;
      sensor_req_q <= 1'b0;
      if (new_frame_d && (state_q != S_IDLE)) overrun_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (new_frame_d) begin
            cmd_q   <= rx_data[7:0];
            addr_q  <= rx_data[15:8];
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          sensor_addr_q <= addr_q;
          // A bad command outranks a bad address.
          if (cmd_q > 8'h02) begin
            code_q  <= 8'hFE;
            value_q <= cmd_q;
            state_q <= S_RESP;
          end else if ({1'b0, addr_q} >= NUM_S9) begin
            code_q  <= 8'hFD;
            value_q <= addr_q;
            state_q <= S_RESP;
          end else begin
            sensor_cmd_q <= cmd_q[1:0];
            sensor_req_q <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A done on the last count cycle still wins over the timeout.
          if (sensor_done) begin
            if (sensor_err) begin
              code_q  <= 8'h1F;
              value_q <= addr_q;
            end else begin
              case (sensor_cmd_q)
                2'b01:   code_q <= 8'h09;
                2'b10:   code_q <= 8'h08;
                default: code_q <= 8'h07;
              endcase
              value_q <= sensor_value;
            end
            state_q <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            code_q  <= 8'hFC;
            value_q <= addr_q;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          if (!tx_busy) begin
            tx_data_q <= {value_q, code_q};
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_command_decoder.sv
// Self-checking bench for command_decoder: directed frames, expected responses queued by the
// drivers and matched by an independent monitor on every tx_start strobe.
module tb_command_decoder;

  localparam int NUM_SENSORS = 32;
  localparam int TMO         = 20;

  logic        clk;
  logic        rst_n;
  logic [15:0] rx_data;
  logic        rx_concluded;
  logic [7:0]  sensor_addr;
  logic [1:0]  sensor_cmd;
  logic        sensor_req;
  logic        sensor_done;
  logic        sensor_err;
  logic [7:0]  sensor_value;
  logic        tx_busy;
  logic        tx_start;
  logic [15:0] tx_data;
  logic        overrun;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_count = 0;
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  command_decoder #(.NUM_SENSORS(NUM_SENSORS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_9k6hz(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_concluded(rx_concluded),
    .sensor_addr(sensor_addr), .sensor_cmd(sensor_cmd), .sensor_req(sensor_req),
    .sensor_done(sensor_done), .sensor_err(sensor_err), .sensor_value(sensor_value),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .overrun(overrun),
    .dbg_state_o(dbg_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each transmit strobe
  always @(negedge clk) begin
    logic [15:0] e;
    int c;
    if (rst_n && sensor_req) req_count++;
    if (rst_n && tx_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_tx_start: got tx_data %h with nothing expected (cycle %0d)",
                 tx_data, cyc);
      end else begin
        e = exp_q.pop_front();
        c = exp_cyc_q.pop_front();
        check("tx_data", {16'h0, tx_data}, {16'h0, e});
        if (c >= 0) check("tx_start_cycle", cyc, c);
        check("tx_start_while_busy", {31'h0, tx_busy}, 32'h0);
      end
    end
  end

  // Driver tasks: inputs change 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] d, input int c);
    exp_q.push_back(d);
    exp_cyc_q.push_back(c);
  endtask

  task automatic send_frame(input logic [15:0] d, input int hold, output int k);
    rx_data      = d;
    rx_concluded = 1'b1;
    k = cyc;
    repeat (hold) tick();
    rx_concluded = 1'b0;
  endtask

  task automatic wait_req(output int r);
    r = -1;
    for (int i = 0; i < 10; i++) begin
      if (sensor_req) begin
        r = cyc;
        break;
      end
      tick();
    end
    if (r < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_req: got no sensor_req within 10 cycles, expected one (cycle %0d)", cyc);
    end
  endtask

  task automatic drain(input int bound);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < bound) begin
      tick();
      i++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    tick();
  endtask

  // Valid frame with sensor answer in the first WAIT cycle; optional tx_busy hold from then.
  task automatic run_valid(input logic [15:0] d, input logic [7:0] ea, input logic [1:0] ec,
                           input logic err, input logic [7:0] val, input logic [15:0] exp,
                           input int busy);
    int k, r;
    send_frame(d, 1, k);
    wait_req(r);
    if (r < 0) return;
    check("req_latency", r, k + 2);
    check("sensor_addr", {24'h0, sensor_addr}, {24'h0, ea});
    check("sensor_cmd", {30'h0, sensor_cmd}, {30'h0, ec});
    push_exp(exp, r + 1 + ((busy > 1) ? busy : 1));
    tick();
    check("req_one_cycle", {31'h0, sensor_req}, 32'h0);
    sensor_done  = 1'b1;
    sensor_err   = err;
    sensor_value = val;
    if (busy > 0) tx_busy = 1'b1;
    tick();
    sensor_done = 1'b0;
    sensor_err  = 1'b0;
    if (busy > 0) begin
      repeat (busy - 1) tick();
      tx_busy = 1'b0;
    end
    drain(40);
  endtask

  // Invalid frame: straight from DECODE to RESP, no sensor request.
  task automatic run_invalid(input logic [15:0] d, input int hold, input logic [15:0] exp);
    int k, rc;
    rc = req_count;
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 2);
    send_frame(d, hold, k);
    drain(20);
    check("no_sensor_req", req_count, rc);
  endtask

  initial begin
    int k, r;
    rst_n = 1'b0; rx_data = '0; rx_concluded = 1'b0;
    sensor_done = 1'b0; sensor_err = 1'b0; sensor_value = '0; tx_busy = 1'b0;
    repeat (3) tick();
    check("rst_state", {29'h0, dbg_state}, 32'h0);
    check("rst_sensor_req", {31'h0, sensor_req}, 32'h0);
    check("rst_tx_start", {31'h0, tx_start}, 32'h0);
    check("rst_tx_data", {16'h0, tx_data}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_sensor_addr", {24'h0, sensor_addr}, 32'h0);
    check("rst_sensor_cmd", {30'h0, sensor_cmd}, 32'h0);
    rst_n = 1'b1;
    tick();

    run_valid(16'h0501, 8'd5,  2'b01, 1'b0, 8'h19, 16'h1909, 0);
    run_valid(16'h1F02, 8'd31, 2'b10, 1'b0, 8'h3C, 16'h3C08, 0);
    run_valid(16'h0A00, 8'd10, 2'b00, 1'b1, 8'h55, 16'h0A1F, 0);
    run_valid(16'h0300, 8'd3,  2'b00, 1'b0, 8'h5A, 16'h5A07, 20);

    run_invalid(16'h0033, 1, 16'h33FE);
    run_invalid(16'h2502, 1, 16'h25FD);
    run_invalid(16'h2002, 1, 16'h20FD);
    run_invalid(16'h2533, 1, 16'h33FE);
    run_invalid(16'h0007, 5, 16'h07FE);
    check("no_overrun_on_held_concluded", {31'h0, overrun}, 32'h0);

    // Sensor never answers
    send_frame(16'h0A00, 1, k);
    wait_req(r);
    if (r >= 0) begin
      push_exp(16'h0AFC, r + TMO + 1);
      drain(TMO + 20);
    end

    // Second frame while waiting
    send_frame(16'h0401, 1, k);
    wait_req(r);
    if (r >= 0) begin
      push_exp(16'h7709, r + 3);
      tick();
      rx_data = 16'h1F00;
      rx_concluded = 1'b1;
      tick();
      rx_concluded = 1'b0;
      check("overrun_set", {31'h0, overrun}, 32'h1);
      check("overrun_state_wait", {29'h0, dbg_state}, 32'h3);
      check("overrun_addr_kept", {24'h0, sensor_addr}, 32'h4);
      sensor_done = 1'b1;
      sensor_value = 8'h77;
      tick();
      sensor_done = 1'b0;
      drain(20);
      check("overrun_back_idle", {29'h0, dbg_state}, 32'h0);
    end

    // Reset during WAIT
    send_frame(16'h0A02, 1, k);
    wait_req(r);
    if (r >= 0) begin
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrst_state", {29'h0, dbg_state}, 32'h0);
      check("midrst_sensor_addr", {24'h0, sensor_addr}, 32'h0);
      check("midrst_sensor_cmd", {30'h0, sensor_cmd}, 32'h0);
      check("midrst_tx_data", {16'h0, tx_data}, 32'h0);
      check("midrst_overrun", {31'h0, overrun}, 32'h0);
      k = req_count;
      sensor_done = 1'b1;
      sensor_value = 8'hEE;
      tick();
      sensor_done = 1'b0;
      repeat (5) tick();
      check("late_done_ignored_state", {29'h0, dbg_state}, 32'h0);
      check("late_done_no_req", req_count, k);
    end

    drain(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
